// File: rtl/axil_reg_ctrl.sv
// AXI4-Lite slave that serialises single read/write accesses onto a word-addressed register bus.
// Optional address range check is enabled by defining AXIL_REG_RANGE_CHECK_EN.
module axil_reg_ctrl #(
  parameter int RD_LAT = 2
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_wstrb,
  output logic        reg_rd_en,
  input  logic [31:0] reg_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WRESP,
    S_RD,
    S_RWAIT,
    S_RRESP
  } state_t;

  localparam logic [2:0]  LAT       = 3'(RD_LAT);
  localparam logic [1:0]  RESP_OK   = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b10;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  state_t      r_state;
  logic        r_last_rd;
  logic        r_ready_en;
  logic        r_err;
  logic [2:0]  r_lat_cnt;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_wr_en;
  logic        r_rd_en;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic w_wr_pend;
  logic w_rd_pend;
  logic w_idle;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_wr_addr_err;
  logic w_rd_addr_err;
  logic w_unused_addr;

  assign w_wr_pend = s_axi_awvalid & s_axi_wvalid;
  assign w_rd_pend = s_axi_arvalid;

  // r_ready_en keeps every ready low while reset is held and for the release cycle
  assign w_idle     = (r_state == S_IDLE) & r_ready_en;
  assign w_grant_wr = w_idle & w_wr_pend & (~w_rd_pend | r_last_rd);
  assign w_grant_rd = w_idle & w_rd_pend & (~w_wr_pend | ~r_last_rd);

`ifdef AXIL_REG_RANGE_CHECK_EN
  assign w_wr_addr_err = |s_axi_awaddr[31:18];
  assign w_rd_addr_err = |s_axi_araddr[31:18];
`else
  assign w_wr_addr_err = 1'b0;
  assign w_rd_addr_err = 1'b0;
`endif

  assign w_unused_addr = ^{s_axi_awaddr[31:18], s_axi_awaddr[1:0],
                           s_axi_araddr[31:18], s_axi_araddr[1:0]};

  assign s_axi_awready = w_grant_wr;
  assign s_axi_wready  = w_grant_wr;
  assign s_axi_arready = w_grant_rd;

  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rdata  = r_rdata;
  assign reg_addr     = r_addr;
  assign reg_wdata    = r_wdata;
  assign reg_wstrb    = r_wstrb;
  assign reg_wr_en    = r_wr_en;
  assign reg_rd_en    = r_rd_en;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state    <= S_IDLE;
      r_last_rd  <= 1'b1;
      r_ready_en <= 1'b0;
      r_err      <= 1'b0;
      r_lat_cnt  <= 3'd0;
      r_addr     <= 16'h0000;
      r_wdata    <= 32'h0000_0000;
      r_wstrb    <= 4'h0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OK;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OK;
      r_rdata    <= 32'h0000_0000;
    end else begin
      r_ready_en <= 1'b1;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_wr) begin
            r_state   <= S_WR;
            r_last_rd <= 1'b0;
            r_addr    <= s_axi_awaddr[17:2];
            r_wdata   <= s_axi_wdata;
            r_wstrb   <= s_axi_wstrb;
            r_err     <= w_wr_addr_err;
            r_wr_en   <= ~w_wr_addr_err;
          end else if (w_grant_rd) begin
            r_state   <= S_RD;
            r_last_rd <= 1'b1;
            r_addr    <= s_axi_araddr[17:2];
            r_err     <= w_rd_addr_err;
            r_rd_en   <= ~w_rd_addr_err;
          end
        end
        S_WR: begin
          r_state  <= S_WRESP;
          r_bvalid <= 1'b1;
          r_bresp  <= r_err ? RESP_ERR : RESP_OK;
        end
        S_WRESP: begin
          if (s_axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RD: begin
          r_state   <= S_RWAIT;
          r_lat_cnt <= 3'd1;
        end
        S_RWAIT: begin
          // counter equals k during the k-th cycle after the strobe cycle
          if (r_lat_cnt == LAT) begin
            r_state  <= S_RRESP;
            r_rvalid <= 1'b1;
            r_rdata  <= r_err ? ERR_RDATA : reg_rdata;
            r_rresp  <= r_err ? RESP_ERR : RESP_OK;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        S_RRESP: begin
          if (s_axi_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_ctrl.sv
// Scoreboard bench for axil_reg_ctrl: stimulus pushes expected strobes/responses, a monitor pops and checks.
module tb_axil_reg_ctrl;

  localparam int RD_LAT = 2;
`ifdef AXIL_REG_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [15:0] reg_addr;
  logic        reg_wr_en;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_rd_en;
  logic [31:0] reg_rdata;

  axil_reg_ctrl #(.RD_LAT(RD_LAT)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .reg_addr      (reg_addr),
    .reg_wr_en     (reg_wr_en),
    .reg_wdata     (reg_wdata),
    .reg_wstrb     (reg_wstrb),
    .reg_rd_en     (reg_rd_en),
    .reg_rdata     (reg_rdata)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hs;
  } strobe_t;

  typedef struct {
    bit          is_wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hs;
  } resp_t;

  strobe_t strobe_q[$];
  resp_t   resp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_strobe_seen = 0;
  int n_valid_seen  = 0;

  // Register-file model: data is presented only in the RD_LAT-th cycle after reg_rd_en
  logic [31:0] tb_rd_value;
  logic [3:0]  rd_sr = 4'h0;
  always @(posedge s_axi_aclk) rd_sr <= {rd_sr[2:0], reg_rd_en};
  always_comb reg_rdata = rd_sr[RD_LAT-1] ? tb_rd_value : 32'hBAD0_BAD0;

  initial forever begin
    @(posedge s_axi_aclk);
    cyc++;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void note_fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Monitor: pops expectations whenever the DUT strobes the register bus or completes a response
  initial begin
    strobe_t se;
    resp_t   re;
    bit prev_b = 1'b0;
    bit prev_r = 1'b0;
    int b_rise = 0;
    int r_rise = 0;
    logic [1:0]  held_bresp = 2'b00;
    logic [1:0]  held_rresp = 2'b00;
    logic [31:0] held_rdata = 32'h0;
    forever begin
      @(negedge s_axi_aclk);
      if (!s_axi_aresetn) begin
        prev_b = 1'b0;
        prev_r = 1'b0;
        continue;
      end
      if (reg_wr_en || reg_rd_en) begin
        n_strobe_seen++;
        if (strobe_q.size() == 0) begin
          note_fail("unexpected_strobe");
        end else begin
          se = strobe_q.pop_front();
          chk("strobe_kind", 32'(reg_wr_en), 32'(se.is_wr));
          chk("strobe_both", 32'(reg_wr_en & reg_rd_en), 32'h0);
          chk("reg_addr", 32'(reg_addr), 32'(se.addr));
          if (se.is_wr) begin
            chk("reg_wdata", reg_wdata, se.wdata);
            chk("reg_wstrb", 32'(reg_wstrb), 32'(se.wstrb));
          end
          chk("strobe_latency", 32'(cyc - se.hs), 32'd1);
        end
      end
      if (s_axi_bvalid || s_axi_rvalid) n_valid_seen++;
      if (s_axi_bvalid) begin
        if (!prev_b) begin
          b_rise = cyc;
          held_bresp = s_axi_bresp;
        end else begin
          chk("bresp_hold", 32'(s_axi_bresp), 32'(held_bresp));
        end
      end
      if (s_axi_rvalid) begin
        if (!prev_r) begin
          r_rise = cyc;
          held_rresp = s_axi_rresp;
          held_rdata = s_axi_rdata;
        end else begin
          chk("rresp_hold", 32'(s_axi_rresp), 32'(held_rresp));
          chk("rdata_hold", s_axi_rdata, held_rdata);
        end
      end
      if ((s_axi_bvalid && s_axi_bready) || (s_axi_rvalid && s_axi_rready)) begin
        if (resp_q.size() == 0) begin
          note_fail("unexpected_response");
        end else begin
          re = resp_q.pop_front();
          chk("resp_kind", 32'(s_axi_bvalid), 32'(re.is_wr));
          if (re.is_wr) begin
            chk("bresp", 32'(s_axi_bresp), 32'(re.resp));
            chk("b_latency", 32'(b_rise - re.hs), 32'd2);
            $display("[%0d] write done bresp=%b addr=%h", cyc, s_axi_bresp, reg_addr);
          end else begin
            chk("rresp", 32'(s_axi_rresp), 32'(re.resp));
            chk("rdata", s_axi_rdata, re.rdata);
            chk("r_latency", 32'(r_rise - re.hs), 32'(2 + RD_LAT));
            $display("[%0d] read done rresp=%b rdata=%h addr=%h", cyc, s_axi_rresp, s_axi_rdata, reg_addr);
          end
        end
      end
      prev_b = s_axi_bvalid;
      prev_r = s_axi_rvalid;
    end
  end

  task automatic chk_reset();
    chk("rst_awready", 32'(s_axi_awready), 32'h0);
    chk("rst_wready",  32'(s_axi_wready),  32'h0);
    chk("rst_arready", 32'(s_axi_arready), 32'h0);
    chk("rst_bvalid",  32'(s_axi_bvalid),  32'h0);
    chk("rst_rvalid",  32'(s_axi_rvalid),  32'h0);
    chk("rst_strobes", 32'({reg_wr_en, reg_rd_en}), 32'h0);
    chk("rst_reg_addr", 32'(reg_addr), 32'h0);
    chk("rst_reg_wdata", reg_wdata, 32'h0);
    chk("rst_reg_wstrb", 32'(reg_wstrb), 32'h0);
    chk("rst_rdata", s_axi_rdata, 32'h0);
    chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'h0);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (resp_q.size() == 0 && strobe_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge s_axi_aclk);
      #1;
    end
    if (!done) begin
      note_fail("drain_timeout");
      resp_q.delete();
      strobe_q.delete();
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [15:0] ea, input logic [1:0] eresp, input bit estb, input int hold);
    bit ok = 1'b0;
    int hs;
    @(posedge s_axi_aclk); #1;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_bready = (hold == 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge s_axi_aclk);
      if (s_axi_awready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      note_fail("wr_accept_timeout");
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
      return;
    end
    hs = cyc;
    chk("wready_with_awready", 32'(s_axi_wready), 32'h1);
    if (estb) strobe_q.push_back('{1'b1, ea, d, s, hs});
    resp_q.push_back('{1'b1, eresp, 32'h0, hs});
    @(posedge s_axi_aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge s_axi_aclk);
        if (s_axi_bvalid) break;
      end
      repeat (hold) @(negedge s_axi_aclk);
      @(posedge s_axi_aclk); #1;
      s_axi_bready = 1'b1;
    end
    wait_drain();
  endtask

  task automatic rd(input logic [31:0] a, input logic [15:0] ea, input logic [1:0] eresp,
                    input logic [31:0] erdata, input bit estb, input int hold, input logic [31:0] regval);
    bit ok = 1'b0;
    int hs;
    @(posedge s_axi_aclk); #1;
    tb_rd_value = regval;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    s_axi_rready = (hold == 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge s_axi_aclk);
      if (s_axi_arready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      note_fail("rd_accept_timeout");
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
      return;
    end
    hs = cyc;
    if (estb) strobe_q.push_back('{1'b0, ea, 32'h0, 4'h0, hs});
    resp_q.push_back('{1'b0, eresp, erdata, hs});
    @(posedge s_axi_aclk); #1;
    s_axi_arvalid = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge s_axi_aclk);
        if (s_axi_rvalid) break;
      end
      repeat (hold) @(negedge s_axi_aclk);
      @(posedge s_axi_aclk); #1;
      s_axi_rready = 1'b1;
    end
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int hs;
    // All three requests held from reset to exercise round-robin ordering
    s_axi_aresetn = 1'b0;
    s_axi_awaddr  = 32'h0000_0020; s_axi_wdata = 32'hCAFE_0001; s_axi_wstrb = 4'h3;
    s_axi_araddr  = 32'h0000_0104; tb_rd_value = 32'h5555_AAAA;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready  = 1'b1; s_axi_rready = 1'b1;
    repeat (2) @(posedge s_axi_aclk);
    #2;
    chk_reset();
    @(posedge s_axi_aclk); #1;
    s_axi_aresetn = 1'b1;

    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge s_axi_aclk);
        if (s_axi_awready || s_axi_arready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        note_fail("rr_grant_timeout");
        break;
      end
      hs = cyc;
      if (g % 2 == 0) begin
        chk("rr_grant", 32'({s_axi_awready, s_axi_arready}), 32'h2);
        strobe_q.push_back('{1'b1, 16'h0008, 32'hCAFE_0001, 4'h3, hs});
        resp_q.push_back('{1'b1, 2'b00, 32'h0, hs});
      end else begin
        chk("rr_grant", 32'({s_axi_awready, s_axi_arready}), 32'h1);
        strobe_q.push_back('{1'b0, 16'h0041, 32'h0, 4'h0, hs});
        resp_q.push_back('{1'b0, 2'b00, 32'h5555_AAAA, hs});
      end
    end
    @(posedge s_axi_aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    wait_drain();

    // Directed writes and reads
    wr(32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 16'h0004, 2'b00, 1'b1, 0);
    wr(32'h0001_2348, 32'h0000_00FF, 4'h1, 16'h48D2, 2'b00, 1'b1, 3);
    rd(32'h0003_FFFC, 16'hFFFF, 2'b00, 32'h1234_5678, 1'b1, 5, 32'h1234_5678);

    // Lone awvalid must never be accepted
    @(posedge s_axi_aclk); #1;
    s_axi_awaddr = 32'h0000_0ABC; s_axi_wdata = 32'h1357_9BDF; s_axi_wstrb = 4'hC;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge s_axi_aclk);
      chk("lone_aw_ready", 32'({s_axi_awready, s_axi_wready}), 32'h0);
    end
    @(posedge s_axi_aclk); #1;
    s_axi_wvalid = 1'b1;
    @(negedge s_axi_aclk);
    chk("aw_w_accept", 32'({s_axi_awready, s_axi_wready}), 32'h3);
    if (s_axi_awready) begin
      strobe_q.push_back('{1'b1, 16'h02AF, 32'h1357_9BDF, 4'hC, cyc});
      resp_q.push_back('{1'b1, 2'b00, 32'h0, cyc});
    end
    @(posedge s_axi_aclk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    wait_drain();

    // Out-of-range addresses
    rd(32'h0004_0000, 16'h0000, RC ? 2'b10 : 2'b00, RC ? 32'hDEAD_BEEF : 32'h0BAD_F00D, !RC, 0, 32'h0BAD_F00D);
    wr(32'h8000_0044, 32'h0F0F_F0F0, 4'hF, 16'h0011, RC ? 2'b10 : 2'b00, !RC, 0);

    // Reset pulsed while the read waits on register-bus latency
    @(posedge s_axi_aclk); #1;
    tb_rd_value = 32'h7777_0001;
    s_axi_araddr = 32'h0000_0200; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge s_axi_aclk);
      if (s_axi_arready) begin ok = 1'b1; break; end
    end
    if (!ok) note_fail("rst_rd_accept_timeout");
    else strobe_q.push_back('{1'b0, 16'h0080, 32'h0, 4'h0, cyc});
    @(posedge s_axi_aclk); #1;
    s_axi_arvalid = 1'b0;
    @(posedge s_axi_aclk); #1;
    s_axi_aresetn = 1'b0;
    #1;
    chk_reset();
    resp_q.delete();
    strobe_q.delete();
    repeat (2) @(posedge s_axi_aclk);
    #1;
    s_axi_aresetn = 1'b1;
    n_strobe_seen = 0;
    n_valid_seen  = 0;
    repeat (12) @(negedge s_axi_aclk);
    chk("no_strobe_after_reset", 32'(n_strobe_seen), 32'h0);
    chk("no_valid_after_reset", 32'(n_valid_seen), 32'h0);
    rd(32'h0000_0008, 16'h0002, 2'b00, 32'h0BAD_C0DE, 1'b1, 0, 32'h0BAD_C0DE);

    wait_drain();
    chk("final_resp_q_empty", 32'(resp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_ctrl.md
# axil_reg_ctrl

AXI4-Lite slave controller that sequences register accesses from the host interconnect onto the team's single-port, word-addressed register bus. It converts byte addresses to 16-bit word addresses (byte address bits [17:2]). It arbitrates between pending read and write transactions and tracks the register bus's fixed read latency. It sits between the AXI4-Lite crossbar and the 400GbE control/status register file.

## Interface

Parameters:
- RD_LAT, 2: register-bus read latency in cycles, legal range 1..4.

Ports:
- s_axi_aclk  in  1  sole clock; all logic is rising-edge.
- s_axi_aresetn  in  1  reset, asynchronous and active-low.
- s_axi_awaddr  in  32  write byte address.
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  write byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake.
- s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake.
- s_axi_araddr  in  32  read byte address.
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake.
- reg_addr  out  16  word address, equal to captured byte address [17:2].
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wdata  out  32  write data to the register file.
- reg_wstrb  out  4  byte enables to the register file.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rdata  in  32  read data, valid RD_LAT cycles after reg_rd_en.

## Operation

- Only one transaction is outstanding at a time. There is no AXI ID, burst or pipelining support.
- FSM states and transitions:
  - IDLE -> WR on a write grant; IDLE -> RD on a read grant.
  - WR -> WRESP after one cycle.
  - RD -> RWAIT after one cycle.
  - RWAIT -> RRESP when the latency counter reaches RD_LAT.
  - WRESP -> IDLE on bvalid&bready.
  - RRESP -> IDLE on rvalid&rready.
- Write pending means awvalid and wvalid are both high. AW and W are always accepted together: awready and wready are asserted in the same single cycle. A lone awvalid or a lone wvalid waits and is never accepted.
- Read pending means arvalid is high.
- Arbitration applies only in IDLE:
  - If one side is pending, that side wins.
  - If both are pending, round-robin using a last_grant flag. After reset the write side wins first; after that, the side not granted last time wins.
- awready, wready and arready are combinational from the IDLE state, the grant and the valids. Each is high for exactly the acceptance cycle.
- The address is captured on acceptance. reg_addr holds the captured address[17:2] and keeps it until the next acceptance.
- WR state: reg_wr_en=1, with reg_wdata and reg_wstrb taken from the captured W beat.
- RD state: reg_rd_en=1. A counter then waits RD_LAT cycles, and reg_rdata is captured into s_axi_rdata on the RD_LAT-th cycle after the reg_rd_en cycle.
- rdata and rresp are held stable while rvalid=1 and rready=0. bresp is held the same way while bvalid=1 and bready=0.
- An in-flight transaction is never pre-empted. Requests arriving while busy wait until the FSM is back in IDLE.

## Timing

- Reset values (asynchronous):
  - FSM state = IDLE; last_grant = read, so write wins first.
  - All ready and valid outputs = 0; reg_wr_en = reg_rd_en = 0.
  - reg_addr, reg_wdata, reg_wstrb, s_axi_rdata, s_axi_bresp, s_axi_rresp = 0.
- Write: handshake in cycle T; reg_wr_en in T+1; bvalid from T+2.
- Read: handshake in cycle T; reg_rd_en in T+1; rdata captured at the end of T+1+RD_LAT; rvalid from T+2+RD_LAT.
- Minimum spacing between back-to-back writes with bready held high is 3 cycles.
- If reset is asserted mid-transaction, the transaction is dropped immediately. No response is issued and no strobe occurs after reset deasserts.

## Configuration

- AXIL_REG_RANGE_CHECK_EN defined:
  - An access whose byte address bits [31:18] are nonzero gets resp = SLVERR (10).
  - No reg_wr_en or reg_rd_en pulse is issued for that access.
  - For such a read, rdata = 32'hDEAD_BEEF.
  - Response timing is unchanged.
- AXIL_REG_RANGE_CHECK_EN undefined: bits [31:18] are ignored, addresses alias modulo 256 KiB, and resp is always OKAY.

## Test plan

- Write awaddr=0x0000_0010, wdata=0xA5A5_5A5A, wstrb=0xF, bready=1 -> reg_addr=0x0004 and one reg_wr_en pulse in T+1; bvalid in T+2 with bresp=00.
- Read araddr=0x0003_FFFC, RD_LAT=2, reg_rdata=0x1234_5678 -> reg_addr=0xFFFF; rvalid at T+4 with rdata=0x1234_5678; rdata held while rready=0 for 5 cycles.
- awvalid, wvalid and arvalid all held continuously from reset -> grant order is write, read, write, read; exactly one strobe per transaction.
- awvalid high with wvalid low for 10 cycles -> awready stays 0 and no reg_wr_en; wvalid rises -> acceptance in that cycle.
- AXIL_REG_RANGE_CHECK_EN defined, read araddr=0x0004_0000 -> no reg_rd_en; rresp=10 and rdata=0xDEAD_BEEF. With the macro undefined -> reg_addr=0x0000, rresp=00.
- s_axi_aresetn pulsed low during RWAIT -> all outputs return to reset values; no rvalid after release; the next read completes normally.
